pixel_stream_packer: RTL and testbench

- Consumer end of the Mandelbrot pixel stream.
- Accepts one 24-bit RGB pixel per handshake, together with the first/last_x/last_y/valid flags, and drives ready back to the generator.
- Packs every 4 pixels into 3 32-bit words on a valid/ready word stream with start-of-frame (user) and end-of-line (last) sideband, for the downstream video DMA.
- Optionally checks frame geometry and reports protocol errors.

---
 rtl/pixel_stream_packer.sv | 213 +++++++++++++++++++++
 tb/tb_pixel_stream_packer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_packer.sv
// pixel_stream_packer: packs a 24-bit RGB pixel stream (r in the lowest byte)
// into 32-bit words, four pixels per three words, with start-of-frame (out_user)
// and end-of-line (out_last) sideband on a valid/ready word stream.
// Optional geometry checker enabled by defining PIXEL_CHECK_EN; without it
// err is tied low and no checker logic exists.
// A short line whose leftover bytes do not fit in the same word takes one extra
// cycle to flush the zero-padded tail word; ready is held low during that cycle.
module pixel_stream_packer #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int CNT_WIDTH = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        first,
    input  logic        last_x,
    input  logic        last_y,
    input  logic        valid,
    output logic        ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_user,
    output logic        out_last,
    output logic        frame_done,
    output logic        err
);

    generate
        if ((IMG_W % 4) != 0 || (2 ** CNT_WIDTH) < IMG_W || (2 ** CNT_WIDTH) < IMG_H) begin : g_bad_geometry
            $error("pixel_stream_packer: IMG_W must be a multiple of 4 and fit CNT_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;

    phase_e      phase_q, phase_d, ph_eff;
    logic [23:0] buf_q, buf_d, buf_eff, pix;
    logic        sof_q, sof_d, sof_eff;
    logic        flush_q, flush_d;
    logic [31:0] data_q, data_d, word;
    logic        valid_q, valid_d, user_q, user_d, last_q, last_d;
    logic        fdone_q, fdone_d;
    logic        can_load, accept, flush_fire, emit, word_last;

    assign can_load   = !valid_q || out_ready;
    assign ready      = reset && !flush_q && can_load;
    assign accept     = valid && ready;
    assign flush_fire = flush_q && can_load;
    assign pix        = {b, g, r};

    // Phase FSM: decides which word (if any) this cycle emits and what remains buffered.
    always_comb begin
        phase_d   = phase_q;
        buf_d     = buf_q;
        flush_d   = flush_q;
        word      = '0;
        word_last = 1'b0;
        emit      = 1'b0;
        // first restarts packing, dropping any partially gathered bytes
        ph_eff    = first ? PH0 : phase_q;
        buf_eff   = first ? '0 : buf_q;
        if (flush_fire) begin
            word      = {8'h00, buf_q};
            word_last = 1'b1;
            emit      = 1'b1;
            buf_d     = '0;
            flush_d   = 1'b0;
        end else if (accept) begin
            case (ph_eff)
                PH0: begin
                    if (last_x) begin
                        word      = {8'h00, pix};
                        word_last = 1'b1;
                        emit      = 1'b1;
                        buf_d     = '0;
                        phase_d   = PH0;
                    end else begin
                        buf_d   = pix;
                        phase_d = PH1;
                    end
                end
                PH1: begin
                    word    = {r, buf_eff};
                    emit    = 1'b1;
                    buf_d   = {8'h00, b, g};
                    phase_d = last_x ? PH0 : PH2;
                    flush_d = last_x;
                end
                PH2: begin
                    word    = {g, r, buf_eff[15:0]};
                    emit    = 1'b1;
                    buf_d   = {16'h0000, b};
                    phase_d = last_x ? PH0 : PH3;
                    flush_d = last_x;
                end
                PH3: begin
                    word      = {b, g, r, buf_eff[7:0]};
                    word_last = last_x;
                    emit      = 1'b1;
                    buf_d     = '0;
                    phase_d   = PH0;
                end
                default: ;
            endcase
        end
    end

    // Output register and sideband: load on emit, drain on out_ready, hold otherwise.
    always_comb begin
        sof_eff = sof_q || (accept && first);
        sof_d   = emit ? 1'b0 : sof_eff;
        data_d  = data_q;
        valid_d = valid_q;
        user_d  = user_q;
        last_d  = last_q;
        if (emit) begin
            data_d  = word;
            valid_d = 1'b1;
            user_d  = sof_eff;
            last_d  = word_last;
        end else if (out_ready) begin
            valid_d = 1'b0;
            user_d  = 1'b0;
            last_d  = 1'b0;
        end
        fdone_d = accept && last_x && last_y;
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= PH0;
            buf_q   <= '0;
            sof_q   <= 1'b0;
            flush_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            buf_q   <= buf_d;
            sof_q   <= sof_d;
            flush_q <= flush_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            user_q  <= user_d;
            last_q  <= last_d;
            fdone_q <= fdone_d;
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign out_user   = user_q;
    assign out_last   = last_q;
    assign frame_done = fdone_q;

`ifdef PIXEL_CHECK_EN
    localparam logic [CNT_WIDTH-1:0] X_LAST = CNT_WIDTH'(IMG_W - 1);
    localparam logic [CNT_WIDTH-1:0] Y_LAST = CNT_WIDTH'(IMG_H - 1);

    logic [CNT_WIDTH-1:0] x_q, x_d, y_q, y_d, x_eff, y_eff;
    logic                 err_q, err_d, bad;

    // Geometry tracking: position counters and the sticky error flag.
    always_comb begin
        x_eff = first ? '0 : x_q;
        y_eff = first ? '0 : y_q;
        x_d   = x_q;
        y_d   = y_q;
        err_d = err_q;
        bad   = 1'b0;
        if (accept) begin
            bad = (first && (x_q != '0 || y_q != '0))
               || (last_x && (x_eff != X_LAST))
               || (!last_x && (x_eff == X_LAST))
               || (last_x && (last_y != (y_eff == Y_LAST)));
            err_d = err_q || bad;
            if (last_x) begin
                x_d = '0;
                y_d = last_y ? '0 : y_eff + 1'b1;
            end else begin
                x_d = x_eff + 1'b1;
                y_d = y_eff;
            end
        end
    end

    // Checker registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q   <= '0;
            y_q   <= '0;
            err_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Bench for pixel_stream_packer (IMG_W=8, IMG_H=2). A byte-queue reference model
// pushes expected words when pixels are driven; a monitor pops them on each
// output handshake.
module tb_pixel_stream_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  r, g, b;
    logic        first, last_x, last_y, valid;
    logic        ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_user, out_last, frame_done, err;

    pixel_stream_packer #(.IMG_W(8), .IMG_H(2), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .r(r), .g(g), .b(b),
        .first(first), .last_x(last_x), .last_y(last_y), .valid(valid),
        .ready(ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_user(out_user), .out_last(out_last),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        user;
        logic        last;
    } word_t;

    word_t    exp_q[$];
    logic [7:0] mbytes[$];
    logic     msof = 1'b0;
    int       checks = 0;
    int       failures = 0;
    int       fd_count = 0;
    int       fd_exp = 0;
    bit       gaps = 1'b0;
    bit       rnd_rdy = 1'b0;
`ifdef PIXEL_CHECK_EN
    localparam logic ERR_ON_BAD = 1'b1;
`else
    localparam logic ERR_ON_BAD = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, expv);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input logic l);
        exp_q.push_back({w, msof, l});
        msof = 1'b0;
    endtask

    // Reference: bytes r,g,b appended; every 4 bytes form a word; a line end pads.
    task automatic model_pixel(input int k, input bit f, input bit lx);
        logic [31:0] w;
        if (f) begin
            mbytes.delete();
            msof = 1'b1;
        end
        mbytes.push_back(8'(3 * k));
        mbytes.push_back(8'(3 * k + 1));
        mbytes.push_back(8'(3 * k + 2));
        while (mbytes.size() >= 4) begin
            w = {mbytes[3], mbytes[2], mbytes[1], mbytes[0]};
            repeat (4) void'(mbytes.pop_front());
            push_word(w, lx && (mbytes.size() == 0));
        end
        if (lx && mbytes.size() > 0) begin
            w = '0;
            for (int i = 0; i < mbytes.size(); i++) w[8*i +: 8] = mbytes[i];
            mbytes.delete();
            push_word(w, 1'b1);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_pixel(input int k, input bit f, input bit lx, input bit ly);
        bit acc;
        int t;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        r = 8'(3 * k); g = 8'(3 * k + 1); b = 8'(3 * k + 2);
        first = f; last_x = lx; last_y = ly; valid = 1'b1;
        model_pixel(k, f, lx);
        acc = 1'b0;
        t = 0;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = ready;
            @(posedge clk);
            #1;
            t++;
        end
        valid = 1'b0; first = 1'b0; last_x = 1'b0; last_y = 1'b0;
        chk("pixel_accepted", {31'd0, acc}, 32'd1);
        if (lx && ly) begin
            fd_exp++;
            @(negedge clk);
            chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame();
        for (int k = 0; k < 16; k++) send_pixel(k, k == 0, (k % 8) == 7, k >= 8);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        exp_q.delete();
        mbytes.delete();
        msof = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Output monitor: scoreboard compare on handshake, ready check while stalled.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (out_valid && !out_ready) chk("ready_while_stalled", {31'd0, ready}, 32'd0);
            if (out_valid && out_ready) begin
                checks++;
                assert (exp_q.size() > 0) else begin
                    failures++;
                    $error("FAIL extra_word observed=%h expected=none", out_data);
                end
                if (exp_q.size() > 0) begin
                    word_t e;
                    e = exp_q.pop_front();
                    chk("word_data", out_data, e.data);
                    chk("word_user", {31'd0, out_user}, {31'd0, e.user});
                    chk("word_last", {31'd0, out_last}, {31'd0, e.last});
                end
            end
            if (frame_done) fd_count++;
        end
    end

    // Random downstream back-pressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        r = '0; g = '0; b = '0;
        first = 1'b0; last_x = 1'b0; last_y = 1'b0; valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_user_last", {30'd0, out_user, out_last}, 32'd0);
        chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;

        // Full 8x2 frame, no back-pressure
        send_frame();
        drain();
        chk("frame_err", {31'd0, err}, 32'd0);

        // Stall after the first word
        out_ready = 1'b0;
        send_pixel(0, 1'b1, 1'b0, 1'b0);
        send_pixel(1, 1'b0, 1'b0, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_ready", {31'd0, ready}, 32'd0);
            chk("stall_data", out_data, 32'h03020100);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 2; k < 16; k++) send_pixel(k, 1'b0, (k % 8) == 7, k >= 8);
        drain();

        // Random gaps and back-pressure
        gaps = 1'b1;
        rnd_rdy = 1'b1;
        send_frame();
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        gaps = 1'b0;
        drain();
        chk("random_err", {31'd0, err}, 32'd0);

        // Short 6-pixel line, then a 4-pixel line to show packing restarted
        for (int k = 0; k < 6; k++) send_pixel(k, k == 0, k == 5, 1'b0);
        for (int k = 6; k < 10; k++) send_pixel(k, 1'b0, k == 9, 1'b0);
        drain();
        chk("short_line_err", {31'd0, err}, {31'd0, ERR_ON_BAD});
        do_reset();
        chk("err_cleared", {31'd0, err}, 32'd0);

        // first reasserted mid-line at k=2
        send_pixel(0, 1'b1, 1'b0, 1'b0);
        send_pixel(1, 1'b0, 1'b0, 1'b0);
        for (int k = 2; k < 10; k++) send_pixel(k, k == 2, k == 9, 1'b0);
        drain();
        chk("first_mid_err", {31'd0, err}, {31'd0, ERR_ON_BAD});
        do_reset();

        // Reset mid-line with a word held, then a clean frame
        for (int k = 0; k < 5; k++) send_pixel(k, k == 0, 1'b0, 1'b0);
        out_ready = 1'b0;
        send_pixel(5, 1'b0, 1'b0, 1'b0);
        do_reset();
        out_ready = 1'b1;
        send_frame();
        drain();
        chk("post_reset_err", {31'd0, err}, 32'd0);
        chk("frame_done_count", fd_count, fd_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
